// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer for the 5-stage core: per-register enables and
// bubble flushes, single-outstanding cache-fill handshake and stall/miss counters.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned TO_W         = 8,
  parameter int unsigned FILL_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inMemRead_IDEX,
  input  logic [4:0]       inRt_IDEX,
  input  logic [4:0]       inRs_IFID,
  input  logic [4:0]       inRt_IFID,
  input  logic             inBranchTaken,
  input  logic             inImemHit,
  input  logic             inDmemAccess,
  input  logic             inDmemHit,
  input  logic             inFillDone,
  output logic             outEnPC,
  output logic             outEnIFID,
  output logic             outEnIDEX,
  output logic             outEnEXMEM,
  output logic             outEnMEMWB,
  output logic             outFlushIFID,
  output logic             outFlushIDEX,
  output logic             outFillReq,
  output logic             outFillIsData,
  output logic             outFillError,
  output logic [CNT_W-1:0] outStallCycles,
  output logic [CNT_W-1:0] outMissCount
);

  typedef enum logic [1:0] {RUN, IFILL, DFILL} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FILL_TIMEOUT - 32'd1);

  state_t          state;
  state_t          nextState;
  logic [4:0]      en;          // {PC, IFID, IDEX, EXMEM, MEMWB}
  logic            flushIFID;
  logic            flushIDEX;
  logic            fillStart;
  logic            fillDone;
  logic            loadUse;
  logic            dMiss;
  logic            iMiss;
  logic [TO_W-1:0] toCount;

  assign loadUse  = inMemRead_IDEX && (inRt_IDEX != 5'd0) &&
                    ((inRt_IDEX == inRs_IFID) || (inRt_IDEX == inRt_IFID));
  assign dMiss    = inDmemAccess && !inDmemHit;
  assign iMiss    = !inImemHit;
  assign fillDone = (state != RUN) && inFillDone;

  assign outEnPC      = en[4];
  assign outEnIFID    = en[3];
  assign outEnIDEX    = en[2];
  assign outEnEXMEM   = en[1];
  assign outEnMEMWB   = en[0];
  assign outFlushIFID = flushIFID;
  assign outFlushIDEX = flushIDEX;

  // Next state and same-cycle enables/flushes
  always_comb begin
    en        = 5'b11111;
    flushIFID = 1'b0;
    flushIDEX = 1'b0;
    nextState = state;
    fillStart = 1'b0;
    if (reset) begin
      en        = 5'b00000;
      flushIFID = 1'b1;
      flushIDEX = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (dMiss) begin
            en        = 5'b00000;
            nextState = DFILL;
            fillStart = 1'b1;
          end else if (inBranchTaken) begin
            flushIFID = 1'b1;
            flushIDEX = 1'b1;
          end else if (loadUse) begin
            en[4]     = 1'b0;
            en[3]     = 1'b0;
            flushIDEX = 1'b1;
            if (iMiss) begin
              nextState = IFILL;
              fillStart = 1'b1;
            end
          end else if (iMiss) begin
            en[4]     = 1'b0;
            flushIFID = 1'b1;
            nextState = IFILL;
            fillStart = 1'b1;
          end
        end
        IFILL: begin
          en[4] = 1'b0;
          // A flush during the data freeze would drop the instruction held in ID/EX
          if (dMiss) begin
            en = 5'b00000;
          end else if (inBranchTaken) begin
            flushIFID = 1'b1;
            flushIDEX = 1'b1;
          end else if (loadUse) begin
            en[3]     = 1'b0;
            flushIDEX = 1'b1;
          end else begin
            flushIFID = 1'b1;
          end
          if (inFillDone) nextState = RUN;
        end
        DFILL: begin
          en = 5'b00000;
          if (inFillDone) nextState = RUN;
        end
        default: nextState = RUN;
      endcase
    end
  end

  // State, fill handshake, timeout and performance counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= RUN;
      outFillReq     <= 1'b0;
      outFillIsData  <= 1'b0;
      outFillError   <= 1'b0;
      toCount        <= '0;
      outStallCycles <= '0;
      outMissCount   <= '0;
    end else begin
      state <= nextState;
      if (fillStart) begin
        outFillReq    <= 1'b1;
        outFillIsData <= (nextState == DFILL);
      end else if (fillDone) begin
        outFillReq <= 1'b0;
      end
      if (fillStart) begin
        toCount <= '0;
      end else if ((state != RUN) && (toCount != '1)) begin
        toCount <= toCount + TO_W'(1);
      end
      if ((state != RUN) && (toCount == TO_LAST)) outFillError <= 1'b1;
      if (!en[4] && (outStallCycles != '1)) outStallCycles <= outStallCycles + CNT_W'(1);
      if (fillDone && (outMissCount != '1)) outMissCount <= outMissCount + CNT_W'(1);
    end
  end

endmodule
